// File: rtl/alu7_pkg.sv
// Shared types for the 7-bit ALU result path: operation tag and buffered entry layout.
package alu7_pkg;

   localparam int ALU7_W = 7;

   typedef enum logic {
      OP_NAND = 1'b0,
      OP_ROL  = 1'b1
   } alu7_op_e;

   typedef struct packed {
      alu7_op_e          op;
      logic [ALU7_W-1:0] result;
      logic              zero;
      logic              parity;
   } alu7_entry_t;

endpackage

// File: rtl/alu7_flags.sv
// Combinational zero/parity flag generator for a 7-bit ALU result.
module alu7_flags
   import alu7_pkg::*;
(
   input  logic [ALU7_W-1:0] value,
   output logic              zero,
   output logic              parity
);

   always_comb begin
      zero   = (value == '0);
      parity = ^value;
   end

endmodule

// File: rtl/alu7_result_stage.sv
// Registered 2-entry result buffer behind the 7-bit ALU with a delivered-result counter.
// Optional flag logic is built when ALU7_FLAGS_EN is defined.
module alu7_result_stage
   import alu7_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int CNT_W = 8
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              in_op,
   input  logic [ALU7_W-1:0] in_result,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_op,
   output logic [ALU7_W-1:0] out_result,
   output logic              out_zero,
   output logic              out_parity,
   input  logic              cnt_clr,
   output logic [CNT_W-1:0]  dlv_cnt
);

   alu7_entry_t mem [DEPTH];
   alu7_entry_t head;
   alu7_entry_t wr_entry;
   logic        wptr;
   logic        rptr;
   logic [1:0]  count;
   logic        push;
   logic        pop;
   logic        in_zero;
   logic        in_parity;

`ifdef ALU7_FLAGS_EN
   alu7_flags u_flags (
      .value  (in_result),
      .zero   (in_zero),
      .parity (in_parity)
   );
`else
   // Flag bits are written as constant 0, so their storage collapses away.
   assign in_zero   = 1'b0;
   assign in_parity = 1'b0;
`endif

   always_comb begin
      in_ready  = (count != 2'(DEPTH));
      out_valid = (count != '0);
      push      = in_valid & in_ready;
      pop       = out_valid & out_ready;
      head      = mem[rptr];
      wr_entry  = '{op: alu7_op_e'(in_op), result: in_result,
                    zero: in_zero, parity: in_parity};
   end

   assign out_op     = head.op;
   assign out_result = head.result;
   assign out_zero   = head.zero;
   assign out_parity = head.parity;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (push) begin
         mem[wptr] <= wr_entry;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr  <= 1'b0;
         rptr  <= 1'b0;
         count <= '0;
      end else begin
         if (push) wptr <= ~wptr;
         if (pop)  rptr <= ~rptr;
         case ({push, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

   // A clear on the same edge as a pop takes priority; that pop goes uncounted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dlv_cnt <= '0;
      end else if (cnt_clr) begin
         dlv_cnt <= '0;
      end else if (pop) begin
         dlv_cnt <= dlv_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_alu7_result_stage.sv
// Scoreboard bench for alu7_result_stage; flag expectations follow ALU7_FLAGS_EN.
module tb_alu7_result_stage;

   typedef struct {
      logic       op;
      logic [6:0] result;
      logic       zero;
      logic       parity;
   } exp_t;

   logic       clk;
   logic       rst_n;
   logic       in_valid;
   logic       in_ready;
   logic       in_op;
   logic [6:0] in_result;
   logic       out_valid;
   logic       out_ready;
   logic       out_op;
   logic [6:0] out_result;
   logic       out_zero;
   logic       out_parity;
   logic       cnt_clr;
   logic [7:0] dlv_cnt;

   exp_t       q[$];
   logic [7:0] exp_cnt;
   int         n_checks;
   int         n_err;

   alu7_result_stage #(.DEPTH(2), .CNT_W(8)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_op      (in_op),
      .in_result  (in_result),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_op     (out_op),
      .out_result (out_result),
      .out_zero   (out_zero),
      .out_parity (out_parity),
      .cnt_clr    (cnt_clr),
      .dlv_cnt    (dlv_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic exp_t mk(input logic op, input logic [6:0] r);
      exp_t e;
      int   ones;
      e.op     = op;
      e.result = r;
      ones = 0;
      for (int b = 0; b < 7; b++) ones += int'(r[b]);
`ifdef ALU7_FLAGS_EN
      e.zero   = (ones == 0);
      e.parity = ones[0];
`else
      e.zero   = 1'b0;
      e.parity = 1'b0;
`endif
      return e;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Checks all outputs against the scoreboard, then advances one clock.
   task automatic cycle();
      int   n;
      logic do_pop;
      logic do_push;
      n = q.size();
      chk("out_valid", 32'(out_valid), 32'(n != 0));
      chk("in_ready", 32'(in_ready), 32'(n != 2));
      chk("dlv_cnt", 32'(dlv_cnt), 32'(exp_cnt));
      if (n != 0) begin
         chk("out_op", 32'(out_op), 32'(q[0].op));
         chk("out_result", 32'(out_result), 32'(q[0].result));
         chk("out_zero", 32'(out_zero), 32'(q[0].zero));
         chk("out_parity", 32'(out_parity), 32'(q[0].parity));
      end
      do_pop  = (n != 0) && out_ready;
      do_push = in_valid && (n != 2);
      if (do_pop) void'(q.pop_front());
      if (cnt_clr)     exp_cnt = '0;
      else if (do_pop) exp_cnt = exp_cnt + 8'd1;
      if (do_push) q.push_back(mk(in_op, in_result));
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
      chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
      chk({tag, "_dlv_cnt"}, 32'(dlv_cnt), 32'd0);
      chk({tag, "_out_op"}, 32'(out_op), 32'd0);
      chk({tag, "_out_result"}, 32'(out_result), 32'd0);
      chk({tag, "_out_zero"}, 32'(out_zero), 32'd0);
      chk({tag, "_out_parity"}, 32'(out_parity), 32'd0);
   endtask

   initial begin
      n_checks  = 0;
      n_err     = 0;
      exp_cnt   = '0;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_op     = 1'b0;
      in_result = '0;
      out_ready = 1'b0;
      cnt_clr   = 1'b0;

      // Reset, then idle
      repeat (2) @(posedge clk);
      #1;
      check_reset_outputs("reset");
      rst_n = 1'b1;
      repeat (2) cycle();

      // Single NAND 0x00 with consumer ready
      out_ready = 1'b1;
      in_valid = 1'b1; in_op = 1'b0; in_result = 7'h00;
      cycle();
      in_valid = 1'b0; in_op = 1'bx; in_result = 'x;
      cycle();
      cycle();
      chk("single_cnt", 32'(dlv_cnt), 32'd1);

      // Backpressure: fill both entries, hold, then drain in order
      out_ready = 1'b0;
      in_valid = 1'b1; in_op = 1'b1; in_result = 7'h55;
      cycle();
      in_result = 7'h2A;
      cycle();
      in_result = 7'h7F;
      repeat (5) cycle();
      in_valid = 1'b0;
      chk("bp_head", 32'(out_result), 32'h55);
      out_ready = 1'b1;
      repeat (3) cycle();
      chk("bp_cnt", 32'(dlv_cnt), 32'd3);

      // Clear, then stream 300 results back to back
      cnt_clr = 1'b1;
      cycle();
      cnt_clr = 1'b0;
      for (int i = 0; i < 300; i++) begin
         in_valid  = 1'b1;
         in_op     = 1'($urandom_range(0, 1));
         in_result = 7'($urandom);
         cycle();
      end
      in_valid = 1'b0;
      repeat (2) cycle();
      chk("stream_cnt", 32'(dlv_cnt), 32'd44);

      // Pop coinciding with cnt_clr is not counted
      out_ready = 1'b0;
      in_valid = 1'b1; in_op = 1'b0; in_result = 7'h13;
      cycle();
      in_valid = 1'b0;
      out_ready = 1'b1; cnt_clr = 1'b1;
      cycle();
      cnt_clr = 1'b0;
      chk("clr_pop_cnt", 32'(dlv_cnt), 32'd0);
      in_valid = 1'b1; in_result = 7'h40;
      cycle();
      in_valid = 1'b0;
      cycle();
      chk("after_clr_cnt", 32'(dlv_cnt), 32'd1);
      cycle();

      // Asynchronous reset with two entries buffered
      out_ready = 1'b0;
      in_valid = 1'b1; in_op = 1'b1; in_result = 7'h01;
      cycle();
      in_result = 7'h7E;
      cycle();
      in_valid = 1'b0;
      chk("prereset_valid", 32'(out_valid), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_outputs("async_reset");
      q.delete();
      exp_cnt = '0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      out_ready = 1'b1;
      repeat (2) cycle();
      check_reset_outputs("post_reset");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
